// File: rtl/draw_manager.sv
// Frame draw sequencer: optionally clears the framebuffer, then grants the shared pixel bus
// to each source in ascending ID order and forwards in-range, opaque pixels as registered writes.
// Optional feature macro: DRAW_MGR_CLEAR_EN (framebuffer clear to BG_COLOR at start of frame).
module draw_manager #(
  parameter int                     NUM_SOURCES   = 4,
  parameter int                     COLOR_DEPTH   = 9,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR      = '0,
  parameter int                     GRANT_TIMEOUT = 1024,
  localparam int                    SEL_W         = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame,
  output logic [SEL_W-1:0]       write_source_sel,
  output logic                   write_awaited,
  input  logic                   write_active,
  input  logic [COLOR_DEPTH-1:0] write_color_data,
  input  logic                   write_transparent,
  input  logic [31:0]            write_x_addr,
  input  logic [31:0]            write_y_addr,
  output logic                   fb_we,
  output logic [18:0]            fb_addr,
  output logic [COLOR_DEPTH-1:0] fb_data,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   frame_overrun
);

  localparam int          TMO_W     = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [18:0] LAST_ADDR = 19'd307199;

  typedef enum logic [2:0] {IDLE, CLEAR, GRANT, DRAIN, NEXT, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [SEL_W-1:0]       index_reg, index_next;
  logic [TMO_W-1:0]       timer_reg, timer_next;
  logic [18:0]            clear_addr_reg, clear_addr_next;
  logic                   fb_we_reg, fb_we_next;
  logic [18:0]            fb_addr_reg, fb_addr_next;
  logic [COLOR_DEPTH-1:0] fb_data_reg, fb_data_next;
  logic                   overrun_reg, overrun_next;

  logic        pixel_ok;
  logic [18:0] pixel_addr;

  // y*640 + x computed as (y<<9) + (y<<7) + x; only valid once the range check passes
  assign pixel_ok   = write_active && !write_transparent &&
                      (write_x_addr < 32'd640) && (write_y_addr < 32'd480);
  assign pixel_addr = 19'({write_y_addr[8:0], 9'd0}) + 19'({write_y_addr[8:0], 7'd0}) +
                      19'(write_x_addr[9:0]);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      index_reg      <= '0;
      timer_reg      <= '0;
      clear_addr_reg <= '0;
      fb_we_reg      <= 1'b0;
      fb_addr_reg    <= '0;
      fb_data_reg    <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      timer_reg      <= timer_next;
      clear_addr_reg <= clear_addr_next;
      fb_we_reg      <= fb_we_next;
      fb_addr_reg    <= fb_addr_next;
      fb_data_reg    <= fb_data_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    timer_next      = timer_reg;
    clear_addr_next = clear_addr_reg;
    fb_we_next      = 1'b0;
    fb_addr_next    = fb_addr_reg;
    fb_data_next    = fb_data_reg;
    overrun_next    = overrun_reg | (frame && (state_reg != IDLE));

    case (state_reg)
      IDLE: begin
        if (frame) begin
          index_next = '0;
          timer_next = '0;
`ifdef DRAW_MGR_CLEAR_EN
          state_next      = CLEAR;
          clear_addr_next = '0;
`else
          state_next      = GRANT;
`endif
        end
      end
      CLEAR: begin
        fb_we_next   = 1'b1;
        fb_addr_next = clear_addr_reg;
        fb_data_next = BG_COLOR;
        if (clear_addr_reg == LAST_ADDR) begin
          state_next = GRANT;
          index_next = '0;
          timer_next = '0;
        end else begin
          clear_addr_next = clear_addr_reg + 19'd1;
        end
      end
      GRANT: begin
        // The pixel presented on the cycle write_active rises is accepted as well
        if (write_active) begin
          state_next   = DRAIN;
          fb_we_next   = pixel_ok;
          fb_addr_next = pixel_ok ? pixel_addr : fb_addr_reg;
          fb_data_next = pixel_ok ? write_color_data : fb_data_reg;
        end else if (timer_reg == TMO_W'(GRANT_TIMEOUT - 1)) begin
          state_next = NEXT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (!write_active) begin
          state_next = NEXT;
        end else begin
          fb_we_next   = pixel_ok;
          fb_addr_next = pixel_ok ? pixel_addr : fb_addr_reg;
          fb_data_next = pixel_ok ? write_color_data : fb_data_reg;
        end
      end
      NEXT: begin
        timer_next = '0;
        if (index_reg == SEL_W'(NUM_SOURCES - 1)) begin
          state_next = DONE;
        end else begin
          state_next = GRANT;
          index_next = index_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        index_next = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign write_source_sel = index_reg;
  assign write_awaited    = (state_reg == GRANT);
  assign fb_we            = fb_we_reg;
  assign fb_addr          = fb_addr_reg;
  assign fb_data          = fb_data_reg;
  assign frame_done       = (state_reg == DONE);
  assign busy             = (state_reg != IDLE);
  assign frame_overrun    = overrun_reg;

endmodule
